// File: rtl/sda_xfer_ctrl.sv
// sda_xfer_ctrl: single-byte serial transfer controller driving the SDA pad block and SCL.
// Latency: start_req accepted at T, START from T+1, done at T+1+80*CLK_DIV (full transfer).
// Backpressure: none; start_req is ignored (never queued) while busy or in the done cycle.
//
// Ports:
//   m_clk, m_rst_n          clock, asynchronous active-low reset
//   start_req, rw, addr,    request strobe and transfer descriptor, captured in IDLE
//   wdata
//   sda_i                   SDA level returned from the pad
//   sda_oe, sda_o           pad drive: oe=1 pulls SDA low, sda_o tied 0
//   scl                     serial clock
//   busy, done, ack_err,    status; ack_err/rdata valid in the done cycle
//   rdata
//
// Optional feature macro: SDA_XFER_RETRY_EN -- on address NACK, STOP then retry the
// same transfer up to 3 more times before reporting ack_err.

module sda_xfer_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       m_clk,
  input  logic       m_rst_n,
  input  logic       start_req,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       sda_o,
  output logic       scl,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_AACK  = 4'd3;
  localparam logic [3:0] S_WDATA = 4'd4;
  localparam logic [3:0] S_WACK  = 4'd5;
  localparam logic [3:0] S_RDATA = 4'd6;
  localparam logic [3:0] S_MNACK = 4'd7;
  localparam logic [3:0] S_STOP  = 4'd8;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [3:0] r_state;
  logic [7:0] r_div;
  logic [1:0] r_phase;
  logic [2:0] r_bit;
  logic [7:0] r_abyte;   // {addr, rw}, shifted out MSB first
  logic [7:0] r_wdata;
  logic [7:0] r_shift;
  logic       r_samp;    // last sampled SDA level (ACK slots)
  logic       r_err;     // NACK seen in the current transfer
  logic       r_busy;
  logic       r_done;
  logic       r_ack_err;
  logic [7:0] r_rdata;

  logic w_div_last;
  logic w_sample;
  logic w_bit_end;
  logic w_restart;
  logic w_retry_left;
  logic w_scl;
  logic w_oe;

  assign w_div_last = (r_div == DIV_LAST);
  // Sample point is the last cycle of P2, i.e. just before SCL has been high for a full phase.
  assign w_sample   = w_div_last && (r_phase == 2'd2);
  assign w_bit_end  = w_div_last && (r_phase == 2'd3);

`ifdef SDA_XFER_RETRY_EN
  logic [1:0] r_retry;
  logic       r_restart;

  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      r_retry   <= 2'd0;
      r_restart <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_retry   <= 2'd0;
      r_restart <= 1'b0;
    end else if (w_bit_end && (r_state == S_AACK) && r_samp && (r_retry != 2'd3)) begin
      r_restart <= 1'b1;
    end else if (w_bit_end && (r_state == S_STOP) && r_restart) begin
      r_restart <= 1'b0;
      r_retry   <= r_retry + 2'd1;
    end
  end

  assign w_restart    = r_restart;
  assign w_retry_left = (r_retry != 2'd3);
`else
  assign w_restart    = 1'b0;
  assign w_retry_left = 1'b0;
`endif

  // Pad/SCL levels decode straight from state and phase, so SDA only moves when the
  // state or bit index changes (P0 entry) except in the START/STOP bits.
  always_comb begin
    w_scl = 1'b1;
    w_oe  = 1'b0;
    case (r_state)
      S_START: w_oe = r_phase[1];
      S_ADDR: begin
        w_scl = r_phase[1];
        w_oe  = ~r_abyte[r_bit];
      end
      S_WDATA: begin
        w_scl = r_phase[1];
        w_oe  = ~r_wdata[r_bit];
      end
      S_AACK, S_WACK, S_RDATA, S_MNACK: w_scl = r_phase[1];
      S_STOP: begin
        w_scl = (r_phase != 2'd0);
        w_oe  = (r_phase != 2'd3);
      end
      default: begin
        w_scl = 1'b1;
        w_oe  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= 8'd0;
      r_phase   <= 2'd0;
      r_bit     <= 3'd0;
      r_abyte   <= 8'd0;
      r_wdata   <= 8'd0;
      r_shift   <= 8'd0;
      r_samp    <= 1'b1;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_rdata   <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_div   <= 8'd0;
        r_phase <= 2'd0;
        // r_done blocks a request landing in the done cycle
        if (start_req && !r_done) begin
          r_state   <= S_START;
          r_abyte   <= {addr, rw};
          r_wdata   <= wdata;
          r_busy    <= 1'b1;
          r_ack_err <= 1'b0;
          r_err     <= 1'b0;
        end
      end else begin
        if (w_div_last) begin
          r_div   <= 8'd0;
          r_phase <= r_phase + 2'd1;
        end else begin
          r_div <= r_div + 8'd1;
        end

        if (w_sample) begin
          r_samp <= sda_i;
          if (r_state == S_RDATA) r_shift <= {r_shift[6:0], sda_i};
        end

        if (w_bit_end) begin
          case (r_state)
            S_START: begin
              r_state <= S_ADDR;
              r_bit   <= 3'd7;
            end
            S_ADDR: begin
              if (r_bit == 3'd0) r_state <= S_AACK;
              else               r_bit   <= r_bit - 3'd1;
            end
            S_AACK: begin
              r_bit <= 3'd7;
              if (r_samp) begin
                r_state <= S_STOP;
                if (!w_retry_left) r_err <= 1'b1;
              end else if (r_abyte[0]) begin
                r_state <= S_RDATA;
              end else begin
                r_state <= S_WDATA;
              end
            end
            S_WDATA: begin
              if (r_bit == 3'd0) r_state <= S_WACK;
              else               r_bit   <= r_bit - 3'd1;
            end
            S_WACK: begin
              r_state <= S_STOP;
              if (r_samp) r_err <= 1'b1;
            end
            S_RDATA: begin
              if (r_bit == 3'd0) r_state <= S_MNACK;
              else               r_bit   <= r_bit - 3'd1;
            end
            S_MNACK: r_state <= S_STOP;
            S_STOP: begin
              if (w_restart) begin
                r_state <= S_START;
              end else begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_ack_err <= r_err;
                if (r_abyte[0] && !r_err) r_rdata <= r_shift;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign scl     = w_scl;
  assign sda_oe  = w_oe;
  assign sda_o   = 1'b0;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign rdata   = r_rdata;

endmodule

// File: tb/tb_sda_xfer_ctrl.sv
// Bench for sda_xfer_ctrl: a bus-level slave model decodes START/STOP and SCL edges,
// captures the bytes the master sends, and drives ACK/NACK and read data.
// Table of transfers with hand-computed results, plus reset/collision sequences.

module tb_sda_xfer_ctrl;

  localparam int FULL_CYC = 321;  // 1 + 20 bits * 16 cycles
`ifdef SDA_XFER_RETRY_EN
  localparam int NACK_CYC    = 705;  // 1 + 4 attempts * 11 bits * 16 cycles
  localparam int NACK_STARTS = 4;
`else
  localparam int NACK_CYC    = 177;  // 1 + 11 bits * 16 cycles
  localparam int NACK_STARTS = 1;
`endif

  logic       m_clk = 1'b0;
  logic       m_rst_n = 1'b0;
  logic       start_req = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wdata = 8'd0;
  wire        sda_i;
  logic       sda_oe, sda_o, scl, busy, done, ack_err;
  logic [7:0] rdata;

  logic       slave_low = 1'b0;
  logic       s_nack_addr = 1'b0;
  logic       s_nack_data = 1'b0;
  logic [7:0] s_rbyte = 8'd0;

  int         nbit = 0;
  int         n_start = 0;
  int         n_stop = 0;
  int         n_glitch = 0;
  logic [7:0] cap_addr = 8'd0;
  logic [7:0] cap_data = 8'd0;
  logic       cap_mack = 1'b0;
  logic       pscl = 1'b1;
  logic       psda = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  // Open-drain bus with pull-up: low if either side pulls.
  assign sda_i = ~(sda_oe | slave_low);

  always #5 m_clk = ~m_clk;

  sda_xfer_ctrl #(.CLK_DIV(4)) dut (
    .m_clk    (m_clk),
    .m_rst_n  (m_rst_n),
    .start_req(start_req),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .sda_i    (sda_i),
    .sda_oe   (sda_oe),
    .sda_o    (sda_o),
    .scl      (scl),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .rdata    (rdata)
  );

  // Slave model, evaluated mid-cycle.
  always @(negedge m_clk) begin
    logic cscl, csda;
    cscl = scl;
    csda = sda_i;
    if (!m_rst_n) begin
      slave_low = 1'b0;
    end else begin
      if (pscl && cscl && psda && !csda) begin
        n_start++;
        nbit = 0;
        slave_low = 1'b0;
      end else if (pscl && cscl && !psda && csda) begin
        n_stop++;
        slave_low = 1'b0;
      end else if (pscl && cscl && (psda != csda)) begin
        n_glitch++;
      end
      if (!pscl && cscl) begin
        nbit++;
        if (nbit <= 8)                    cap_addr = {cap_addr[6:0], csda};
        else if (nbit >= 10 && nbit <= 17) cap_data = {cap_data[6:0], csda};
        else if (nbit == 18)              cap_mack = csda;
      end
      if (pscl && !cscl) begin
        if (nbit == 8)
          slave_low = ~s_nack_addr;
        else if (nbit >= 9 && nbit <= 16 && cap_addr[0] && !s_nack_addr)
          slave_low = ~s_rbyte[16 - nbit];
        else if (nbit == 17 && !cap_addr[0])
          slave_low = ~s_nack_data;
        else
          slave_low = 1'b0;
      end
    end
    pscl = cscl;
    psda = csda;
  end

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       nack_addr;
    logic       nack_data;
    logic [7:0] rbyte;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_cyc;
    int         exp_starts;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  k;
    bit  got;
    int  st0, sp0;
    s_nack_addr = v.nack_addr;
    s_nack_data = v.nack_data;
    s_rbyte     = v.rbyte;
    st0 = n_start;
    sp0 = n_stop;
    @(negedge m_clk);
    rw = v.rw; addr = v.addr; wdata = v.wdata; start_req = 1'b1;
    @(negedge m_clk);
    start_req = 1'b0;
    k = 1;
    chk("busy_at_T+1", busy, 1);
    chk("ack_err_cleared_at_accept", ack_err, 0);
    got = 0;
    while (k < 2000 && !got) begin
      if (done) got = 1;
      else begin
        @(negedge m_clk);
        k++;
      end
    end
    chk("done_cycle", k, v.exp_cyc);
    chk("busy_in_done_cycle", busy, 0);
    chk("ack_err", ack_err, v.exp_err);
    chk("rdata", rdata, v.exp_rdata);
    chk("addr_byte_on_bus", cap_addr, {v.addr, v.rw});
    chk("start_count", n_start - st0, v.exp_starts);
    chk("stop_count", n_stop - sp0, v.exp_starts);
    if (!v.nack_addr && !v.rw) chk("write_byte_on_bus", cap_data, v.wdata);
    if (!v.nack_addr && v.rw)  chk("master_nack_bit", cap_mack, 1);
    @(negedge m_clk);
    chk("done_one_cycle", done, 0);
    repeat (3) @(negedge m_clk);
    chk("ack_err_hold", ack_err, v.exp_err);
  endtask

  initial begin
    int ndone, kdone;
    // rw, addr, wdata, nack_addr, nack_data, rbyte, exp_err, exp_rdata, exp_cyc, exp_starts
    vecs[0] = '{1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, FULL_CYC, 1};
    vecs[1] = '{1'b1, 7'h21, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h3C, FULL_CYC, 1};
    vecs[2] = '{1'b0, 7'h2A, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, NACK_CYC, NACK_STARTS};
    vecs[3] = '{1'b0, 7'h7F, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'h3C, FULL_CYC, 1};
    vecs[4] = '{1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 8'h81, FULL_CYC, 1};
    vecs[5] = '{1'b1, 7'h12, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h81, NACK_CYC, NACK_STARTS};
    vecs[6] = '{1'b0, 7'h01, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'h81, FULL_CYC, 1};

    // Reset state
    repeat (3) @(negedge m_clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_sda_o", sda_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_rdata", rdata, 0);
    m_rst_n = 1'b1;
    repeat (2) @(negedge m_clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Collision: request mid-transfer and in the done cycle are both dropped
    s_nack_addr = 1'b0;
    s_nack_data = 1'b0;
    @(negedge m_clk);
    rw = 1'b0; addr = 7'h33; wdata = 8'h0F; start_req = 1'b1;
    @(negedge m_clk);
    start_req = 1'b0;
    ndone = 0;
    kdone = 0;
    for (int k = 1; k <= 700; k++) begin
      start_req = 1'b0;
      if (k == 100) begin
        start_req = 1'b1;
        addr = 7'h44;
      end
      if (done) begin
        ndone++;
        if (kdone == 0) begin
          kdone = k;
          start_req = 1'b1;
        end
      end
      @(negedge m_clk);
      if (kdone == k) chk("req_in_done_cycle_ignored", busy, 0);
    end
    start_req = 1'b0;
    chk("collision_done_count", ndone, 1);
    chk("collision_done_cycle", kdone, FULL_CYC);

    // Async reset in the middle of ADDR
    @(negedge m_clk);
    rw = 1'b0; addr = 7'h00; wdata = 8'h00; start_req = 1'b1;
    @(negedge m_clk);
    start_req = 1'b0;
    repeat (39) @(negedge m_clk);
    chk("mid_addr_sda_oe", sda_oe, 1);
    chk("mid_addr_scl", scl, 0);
    #2 m_rst_n = 1'b0;
    #1;
    chk("async_rst_scl", scl, 1);
    chk("async_rst_sda_oe", sda_oe, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_rdata", rdata, 0);
    @(negedge m_clk);
    m_rst_n = 1'b1;
    repeat (2) @(negedge m_clk);
    run_vec(vecs[0]);

    chk("sda_moved_while_scl_high", n_glitch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
